// File: rtl/mux8way_merge_pkg.sv
// rtl/mux8way_merge_pkg.sv - shared constants and types for the 8-to-1 merger (see MUX8WAY_FIXED_PRIO_EN in top)
package mux8way_merge_pkg;

  localparam int NUM_CH    = 8;
  localparam int SEL_W     = 3;
  localparam int DEF_WIDTH = 16;

  typedef logic [SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/mux8way_merge_arb.sv
// rtl/mux8way_merge_arb.sv - rr_arbiter8: combinational rotate-priority-encode-rotate arbiter
module rr_arbiter8
  import mux8way_merge_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           ptr,
  output logic [NUM_CH-1:0] grant,
  output ch_idx_t           grant_idx
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   rot_req;
  ch_idx_t             offset;
  logic                found;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate the result back
  always_comb begin
    req_dbl   = {req, req};
    rot_req   = req_dbl[ptr +: NUM_CH];
    offset    = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rot_req[i]) begin
        found  = 1'b1;
        offset = ch_idx_t'(i);
      end
    end
    grant_idx = ptr + offset;
    grant     = '0;
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mux8way_merge.sv
// rtl/mux8way_merge.sv - 8-to-1 valid/ready merger with tagged output register; MUX8WAY_FIXED_PRIO_EN selects fixed priority
module mux8way_merge
  import mux8way_merge_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [0:2]              out_sel,
  input  logic                    out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  ch_idx_t           out_sel_q,   out_sel_d;

  logic              can_load;
  logic              load;
  ch_idx_t           arb_ptr;
  logic [NUM_CH-1:0] grant;
  ch_idx_t           grant_idx;
  logic [WIDTH-1:0]  grant_data;

`ifdef MUX8WAY_FIXED_PRIO_EN
  // Scan always starts at channel 0, so channel 0 always wins
  assign arb_ptr = '0;
`else
  ch_idx_t rr_ptr_q, rr_ptr_d;

  // Pointer moves just past the last served channel; holds when nothing is taken
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      rr_ptr_d = grant_idx + ch_idx_t'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign arb_ptr = rr_ptr_q;
`endif

  rr_arbiter8 u_arb (
    .req       (in_valid),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_load = !out_valid_q || out_ready;
  assign load     = !reset && can_load && (|grant);
  assign in_ready = (reset || !can_load) ? '0 : grant;

  // One-hot select of the granted channel's word
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: refill whenever it is empty or draining, else clear valid on drain
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset drops any held word without a handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  // out_sel is declared [0:2] with bit 0 as the LSB of the channel index
  assign out_sel   = {out_sel_q[0], out_sel_q[1], out_sel_q[2]};

endmodule

// File: tb/tb_mux8way_merge.sv
// tb/tb_mux8way_merge.sv - self-checking bench for mux8way_merge (honours MUX8WAY_FIXED_PRIO_EN)
module tb_mux8way_merge;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [0:2]     out_sel;
  logic           out_ready;
  logic [W-1:0]   ch_data [8];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = ch_data[i];
  end

  mux8way_merge #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  function automatic int dut_sel();
    return int'({out_sel[2], out_sel[1], out_sel[0]});
  endfunction

  function automatic int m_grant(logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      int c;
`ifdef MUX8WAY_FIXED_PRIO_EN
      c = k;
`else
      c = (m_ptr + k) % 8;
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_ready();
    logic [7:0] r;
    int g;
    r = '0;
    if (reset || (m_valid && !out_ready)) return r;
    g = m_grant(in_valid);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick(output int acc);
    bit nv;
    logic [W-1:0] nd;
    int ns, np, g;
    nv = m_valid; nd = m_data; ns = m_sel; np = m_ptr; acc = -1;
    if (reset) begin
      nv = 0; nd = '0; ns = 0; np = 0;
    end else begin
      g = m_grant(in_valid);
      if (g >= 0 && (!m_valid || out_ready)) begin
        nv = 1; nd = ch_data[g]; ns = g; np = (g + 1) % 8; acc = g;
      end else if (m_valid && out_ready) begin
        nv = 0;
      end
    end
    @(posedge clk);
    m_valid = nv; m_data = nd; m_sel = ns; m_ptr = np;
    #1;
  endtask

  task automatic step();
    int dummy;
    tick(dummy);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ch_data[i] = 16'h5500 + 16'(i);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 8'h00) begin n_bad++; $display("FAIL reset_in_ready c%0d: got %h want 00", c, in_ready); end
      if (c > 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_cmp++; if (out_sel !== 3'b000) begin n_bad++; $display("FAIL reset_out_sel: got %b want 000", out_sel); end
      end
      step();
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 8'h01) begin n_bad++; $display("FAIL reset_first_grant: got %h want 01", in_ready); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || dut_sel() != 0 || out_data !== 16'h5500) begin
      n_bad++; $display("FAIL reset_first_word: got v=%b sel=%0d d=%h want v=1 sel=0 d=5500", out_valid, dut_sel(), out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 8'h08; ch_data[3] = 16'h1234; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 8'h08) begin n_bad++; $display("FAIL single_in_ready: got %h want 08", in_ready); end
    step();
    in_valid = 8'h00;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h1234 || dut_sel() != 3) begin
      n_bad++; $display("FAIL single_out: got v=%b d=%h sel=%0d want v=1 d=1234 sel=3", out_valid, out_data, dut_sel());
    end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_all_valid();
    int exp_sel;
    do_reset();
    for (int i = 0; i < 8; i++) ch_data[i] = 16'hA000 + 16'(i);
    in_valid = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      @(negedge clk);
`ifdef MUX8WAY_FIXED_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = c % 8;
`endif
      n_cmp++; if (out_valid !== 1'b1 || dut_sel() != exp_sel || out_data !== (16'hA000 + 16'(exp_sel))) begin
        n_bad++; $display("FAIL all_valid c%0d: got v=%b sel=%0d d=%h want v=1 sel=%0d", c, out_valid, dut_sel(), out_data, exp_sel);
      end
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL all_valid_ready c%0d: got %h want %h", c, in_ready, m_ready()); end
    end
  endtask

  task automatic test_backpressure();
    int first, second;
    do_reset();
    out_ready = 1'b0; in_valid = 8'h20; ch_data[5] = 16'h00AA;
    step();
    in_valid = 8'h44; ch_data[2] = 16'h0222; ch_data[6] = 16'h0666;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_data !== 16'h00AA || dut_sel() != 5) begin
        n_bad++; $display("FAIL stall c%0d: got rdy=%h v=%b d=%h sel=%0d want rdy=00 v=1 d=00aa sel=5", c, in_ready, out_valid, out_data, dut_sel());
      end
      step();
    end
`ifdef MUX8WAY_FIXED_PRIO_EN
    first = 2; second = 6;
`else
    first = 6; second = 2;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== (8'h01 << first)) begin n_bad++; $display("FAIL bp_grant1: got %h want ch%0d", in_ready, first); end
    step();
    in_valid[first] = 1'b0;
    @(negedge clk);
    n_cmp++; if (dut_sel() != first || out_data !== ch_data[first]) begin
      n_bad++; $display("FAIL bp_word1: got sel=%0d d=%h want sel=%0d", dut_sel(), out_data, first);
    end
    n_cmp++; if (in_ready !== (8'h01 << second)) begin n_bad++; $display("FAIL bp_grant2: got %h want ch%0d", in_ready, second); end
    step();
    in_valid = 8'h00;
    @(negedge clk);
    n_cmp++; if (dut_sel() != second || out_data !== ch_data[second]) begin
      n_bad++; $display("FAIL bp_word2: got sel=%0d d=%h want sel=%0d", dut_sel(), out_data, second);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; in_valid = 8'h80; ch_data[7] = 16'h0777;
    step();
    in_valid = 8'h81; ch_data[0] = 16'h0100;
    @(negedge clk);
    n_cmp++; if (dut_sel() != 7 || in_ready !== 8'h01) begin
      n_bad++; $display("FAIL wrap_grant: got sel=%0d rdy=%h want sel=7 rdy=01", dut_sel(), in_ready);
    end
    step();
    in_valid = 8'h80;
    @(negedge clk);
    n_cmp++; if (dut_sel() != 0 || out_data !== 16'h0100) begin
      n_bad++; $display("FAIL wrap_word: got sel=%0d d=%h want sel=0 d=0100", dut_sel(), out_data);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    out_ready = 1'b0; in_valid = 8'h20; ch_data[5] = 16'h0555;
    step();
    in_valid = 8'h00;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_stall_hold: got %b want 1", out_valid); end
    reset = 1'b1; in_valid = 8'h41;
    @(negedge clk);
    n_cmp++; if (in_ready !== 8'h00) begin n_bad++; $display("FAIL mid_stall_rst_ready: got %h want 00", in_ready); end
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stall_drop: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 8'h01) begin n_bad++; $display("FAIL mid_stall_ptr: got %h want 01", in_ready); end
    in_valid = 8'h00;
    step();
  endtask

  task automatic test_random();
    int acc;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid[i] = 1'($urandom_range(0, 1));
      ch_data[i] = 16'($urandom);
    end
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL rand_ready c%0d: got %h want %h", c, in_ready, m_ready()); end
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (out_data !== m_data || dut_sel() != m_sel) begin
          n_bad++; $display("FAIL rand_word c%0d: got d=%h sel=%0d want d=%h sel=%0d", c, out_data, dut_sel(), m_data, m_sel);
        end
      end
      tick(acc);
      if (acc >= 0) in_valid[acc] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          ch_data[i] = 16'($urandom);
        end
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
    reset = 1'b1; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) ch_data[i] = '0;
    #1;
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux8way_merge.md
Name: mux8way_merge

Overview:
- Sequential 8-to-1 merger: collects 16-bit words from eight valid/ready source channels and forwards them one at a time onto a single valid/ready output channel.
- Tags each forwarded word with the 3-bit index of the channel it came from.
- Sits upstream of DMux8Way-style distribution logic. Its output index uses the same sel encoding, so a word can be routed back to its source.
- Round-robin arbitration by default, with a one-entry registered output stage.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  8  per-channel valid; bit i is channel i.
- in_data  input  8*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  8  per-channel ready; at most one bit is set per cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data word.
- out_sel  output  [0:2]  registered source index; sel[0] is the LSB (a=000, b=001 … h=111).
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset:
  - out_valid=0, out_data=0, out_sel=000, rr_ptr=0.
  - in_ready=0 during any cycle in which reset=1.
  - Reset mid-transfer discards the held word with no output handshake.
- Handshake:
  - A transfer on channel i happens when in_valid[i] and in_ready[i] are both high on a clock edge.
  - A transfer on the output happens when out_valid and out_ready are both high on a clock edge.
  - Sources must hold data stable and keep valid high until accepted. in_valid must not depend on in_ready.
- Load condition: can_load = !out_valid || out_ready.
  - The output register is refilled in the same cycle it drains, so a continuous stream runs at full throughput of 1 word per clock.
- Arbitration (combinational, each cycle):
  - Scan channels rr_ptr, rr_ptr+1, … rr_ptr+7, modulo 8.
  - grant = the first channel found with in_valid set.
  - in_ready[grant] = can_load. All other in_ready bits are 0.
  - If no channel is valid, no grant is made.
- On an accepted input transfer:
  - out_data <= in_data[grant], out_sel <= grant, out_valid <= 1.
  - rr_ptr <= grant+1. The 3-bit pointer wraps 7 to 0.
- On an output transfer with no new input accepted: out_valid <= 0. out_data and out_sel hold their values.
- No grant in a cycle: rr_ptr holds.
- Output stall (out_valid=1, out_ready=0):
  - All in_ready are 0.
  - out_data and out_sel remain stable.
- Latency: 1 clock from input acceptance to out_valid.
- Fairness: with all eight channels continuously valid and out_ready=1, the service order is 0,1,…,7,0,… with no channel starved. Each channel waits at most 7 words between grants.

Optional Feature:
- Macro: MUX8WAY_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; channel 0 is highest and channel 7 lowest.
  - rr_ptr is removed and the scan always starts at 0.
  - Lower channels can starve higher-numbered ones. Use only for known-sparse traffic.
- Undefined: round-robin behaviour as specified above.
- The handshake, the output register and the reset behaviour are identical in both modes.

Decomposition:
- Shared package holds:
  - localparam NUM_CH=8 and SEL_W=3.
  - A channel-index typedef of SEL_W bits.
  - The default WIDTH constant (16).
- One natural sub-module: rr_arbiter8.
  - Inputs: req[8] and ptr[3].
  - Outputs: a one-hot grant[8] and the encoded grant_idx[3].
  - Purely combinational rotate-priority-encode-rotate.
  - The fixed-priority variant is the same block with ptr tied to 0.

Test Plan:
1. Reset behaviour: assert reset for 2 cycles with all in_valid=1 → out_valid=0, out_sel=000, out_data=0, in_ready=0 throughout; first grant after release goes to channel 0.
2. Single channel: in_valid=00001000, data3=16'h1234, out_ready=1 → in_ready[3]=1; next cycle out_valid=1, out_data=16'h1234, out_sel=011.
3. All valid, out_ready=1 for 16 cycles, channel i data = 16'hA000+i → out_sel sequence 0..7,0..7; one word per cycle with no bubbles.
4. Backpressure: out holds 16'h00AA from ch5 and out_ready=0 for 4 cycles while ch2 and ch6 are valid → in_ready=0 and out_data stable; after out_ready rises, next grant is ch6 (rr_ptr=6), then ch2.
5. Wrap-around: last grant ch7, then only ch0 and ch7 valid → ch0 is granted next.
6. Reset mid-stall: out_valid=1 and out_ready=0, then assert reset for 1 cycle → out_valid=0 next cycle with no output handshake; rr_ptr=0. With MUX8WAY_FIXED_PRIO_EN, repeat scenario 3 → out_sel stays 000 every cycle.
